// File: rtl/branch_predict_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit_if
//  Function : Fetch-prediction, EX-resolution and statistics bundle between
//             the pipeline (master) and the branch predict unit (slave).
//  Revision : 1.0
// ============================================================================
interface branch_predict_unit_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int STAT_W = 16
);
  // IF-stage prediction lookup
  logic [PC_W-1:0]   if_pc;
  logic              pred_taken;
  // EX-stage branch to resolve
  logic              ex_valid;
  logic              ex_stall;
  logic              ex_flush;
  logic [3:0]        ex_branch;
  logic [DATA_W-1:0] ex_op_a;
  logic [DATA_W-1:0] ex_op_b;
  logic [PC_W-1:0]   ex_pc;
  logic              ex_pred_taken;
  // Registered resolution result
  logic              res_valid;
  logic              res_taken;
  logic              res_mispredict;
  logic              res_link;
  // Statistics
  logic              stat_clr;
  logic [STAT_W-1:0] br_count;
  logic [STAT_W-1:0] mp_count;

  modport master (
    output if_pc, ex_valid, ex_stall, ex_flush, ex_branch, ex_op_a, ex_op_b,
           ex_pc, ex_pred_taken, stat_clr,
    input  pred_taken, res_valid, res_taken, res_mispredict, res_link,
           br_count, mp_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_stall, ex_flush, ex_branch, ex_op_a, ex_op_b,
           ex_pc, ex_pred_taken, stat_clr,
    output pred_taken, res_valid, res_taken, res_mispredict, res_link,
           br_count, mp_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predict_unit
//  Function : Branch resolution unit with a bimodal predictor. A table of
//             2-bit saturating counters indexed by PC gives the IF-stage
//             prediction; the EX stage resolves signed branch conditions,
//             trains the table and registers the outcome for flush logic.
//  Revision : 1.0
// ============================================================================
module branch_predict_unit #(
  parameter int         DATA_W      = 32,
  parameter int         PC_W        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         IDX_LSB     = 2,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         STAT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predict_unit_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // Counter states of each table entry
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Branch codes
  localparam logic [3:0] BR_BEQ    = 4'd0;
  localparam logic [3:0] BR_BNE    = 4'd1;
  localparam logic [3:0] BR_BGEZ   = 4'd2;
  localparam logic [3:0] BR_BGTZ   = 4'd3;
  localparam logic [3:0] BR_BLEZ   = 4'd4;
  localparam logic [3:0] BR_BLTZ   = 4'd5;
  localparam logic [3:0] BR_BGEZAL = 4'd6;
  localparam logic [3:0] BR_BLTZAL = 4'd7;

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]        bht [BHT_ENTRIES];
  logic [IDX_W-1:0]  if_idx;
  logic [IDX_W-1:0]  ex_idx;
  logic [1:0]        cnt_cur;
  logic [1:0]        cnt_next;
  logic              bht_we;

  logic              accept;
  logic              is_branch;
  logic              is_link;
  logic              taken;
  logic              mispredict;
  logic              a_neg;
  logic              a_zero;
  logic              a_eq_b;

  logic              res_valid_q;
  logic              res_taken_q;
  logic              res_mispredict_q;
  logic              res_link_q;
  logic [STAT_W-1:0] br_count_q;
  logic [STAT_W-1:0] mp_count_q;

  // PC bits outside the index field are intentionally ignored (aliasing)
  logic              unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc, bus.ex_pc};

  // --------------------------------------------------------------------------
  // Index extraction and EX qualification
  // --------------------------------------------------------------------------
  assign if_idx = bus.if_pc[IDX_LSB +: IDX_W];
  assign ex_idx = bus.ex_pc[IDX_LSB +: IDX_W];

  // Flush kills the instruction even when it is also stalled
  assign accept     = bus.ex_valid & ~bus.ex_stall & ~bus.ex_flush;
  assign is_branch  = ~bus.ex_branch[3];
  assign is_link    = (bus.ex_branch == BR_BGEZAL) | (bus.ex_branch == BR_BLTZAL);
  assign mispredict = taken ^ bus.ex_pred_taken;

  // Two's-complement sign and zero of rs, equality against rt
  assign a_neg  = bus.ex_op_a[DATA_W-1];
  assign a_zero = (bus.ex_op_a == '0);
  assign a_eq_b = (bus.ex_op_a == bus.ex_op_b);

  // Resolve the branch direction; codes 8-15 are non-branches (never taken)
  always_comb begin
    taken = 1'b0;
    case (bus.ex_branch)
      BR_BEQ:    taken = a_eq_b;
      BR_BNE:    taken = ~a_eq_b;
      BR_BGEZ:   taken = ~a_neg;
      BR_BGTZ:   taken = ~a_neg & ~a_zero;
      BR_BLEZ:   taken = a_neg | a_zero;
      BR_BLTZ:   taken = a_neg;
      BR_BGEZAL: taken = ~a_neg;
      BR_BLTZAL: taken = a_neg;
      default:   taken = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Counter table: state register / next-state / output
  // --------------------------------------------------------------------------
  assign bht_we  = accept & is_branch;
  assign cnt_cur = bht[ex_idx];

  // State register: every entry restarts at CNT_INIT, one entry trained per accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= CNT_INIT;
      end
    end else if (bht_we) begin
      bht[ex_idx] <= cnt_next;
    end
  end

  // Next state: taken moves toward ST, not-taken toward SNT, saturating at both ends
  always_comb begin
    cnt_next = cnt_cur;
    case (cnt_cur)
      SNT:     cnt_next = taken ? WNT : SNT;
      WNT:     cnt_next = taken ? WT  : SNT;
      WT:      cnt_next = taken ? ST  : WNT;
      ST:      cnt_next = taken ? ST  : WT;
      default: cnt_next = cnt_cur;
    endcase
  end

  // Output: prediction is the counter MSB, read without write bypass
  always_comb begin
    bus.pred_taken = bht[if_idx][1];
  end

  // --------------------------------------------------------------------------
  // Registered resolution result
  // --------------------------------------------------------------------------
  // Pulse res_valid per accepted instruction; other fields hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_link_q       <= 1'b0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_taken_q      <= taken;
        res_mispredict_q <= mispredict;
        res_link_q       <= is_link;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
  // Saturating branch / mispredict counters; clear takes priority over counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else if (bus.stat_clr) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      if (accept && is_branch && (br_count_q != STAT_MAX)) begin
        br_count_q <= br_count_q + 1'b1;
      end
      if (accept && mispredict && (mp_count_q != STAT_MAX)) begin
        mp_count_q <= mp_count_q + 1'b1;
      end
    end
  end

  assign bus.res_valid      = res_valid_q;
  assign bus.res_taken      = res_taken_q;
  assign bus.res_mispredict = res_mispredict_q;
  assign bus.res_link       = res_link_q;
  assign bus.br_count       = br_count_q;
  assign bus.mp_count       = mp_count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predict_unit
//  Function : Self-checking bench for branch_predict_unit (STAT_W = 4) using
//             directed scenarios and random traffic against a reference model.
//  Revision : 1.0
// ============================================================================
module tb_branch_predict_unit;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int STAT_W = 4;
  localparam int NENT   = 64;
  localparam int SMAX   = 15;

  logic clk;
  logic rst_n;

  branch_predict_unit_if #(.DATA_W(DATA_W), .PC_W(PC_W), .STAT_W(STAT_W)) bus ();

  branch_predict_unit #(
    .DATA_W(DATA_W), .PC_W(PC_W), .BHT_ENTRIES(NENT), .IDX_LSB(2),
    .CNT_INIT(2'b01), .STAT_W(STAT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int bht_m [NENT];
  int br_m, mp_m;
  bit e_valid, e_taken, e_mp, e_link;
  int n_checks, n_errors;

  // One comparison: count it, report a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  // Branch direction from the instruction set definition
  function automatic bit ref_taken(input int code, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (code)
      0:       return a == b;
      1:       return a != b;
      2, 6:    return sa >= 0;
      3:       return sa > 0;
      4:       return sa <= 0;
      5, 7:    return sa < 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) bht_m[i] = 1;
    br_m = 0; mp_m = 0;
    e_valid = 0; e_taken = 0; e_mp = 0; e_link = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check({pfx, "_res_valid"}, bus.res_valid, e_valid);
    check({pfx, "_res_taken"}, bus.res_taken, e_taken);
    check({pfx, "_res_mispredict"}, bus.res_mispredict, e_mp);
    check({pfx, "_res_link"}, bus.res_link, e_link);
    check({pfx, "_br_count"}, bus.br_count, br_m);
    check({pfx, "_mp_count"}, bus.mp_count, mp_m);
  endtask

  // One clock of stimulus, entered and left at posedge+1
  task automatic step(input bit v, input bit st, input bit fl, input int code,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                      input bit pt, input bit clr, input logic [31:0] ifpc);
    bit acc, tk;
    int k;
    bus.ex_valid      = v;
    bus.ex_stall      = st;
    bus.ex_flush      = fl;
    bus.ex_branch     = code[3:0];
    bus.ex_op_a       = a;
    bus.ex_op_b       = b;
    bus.ex_pc         = pc;
    bus.ex_pred_taken = pt;
    bus.stat_clr      = clr;
    bus.if_pc         = ifpc;
    #1;
    check("pred_taken", bus.pred_taken, bht_m[idx_of(ifpc)] >= 2);
    acc = v && !st && !fl;
    tk  = ref_taken(code, a, b);
    @(posedge clk);
    #1;
    e_valid = acc;
    if (acc) begin
      e_taken = tk;
      e_mp    = tk ^ pt;
      e_link  = (code == 6) || (code == 7);
      if (code < 8) begin
        k = idx_of(pc);
        bht_m[k] = tk ? ((bht_m[k] < 3) ? bht_m[k] + 1 : 3)
                      : ((bht_m[k] > 0) ? bht_m[k] - 1 : 0);
        if (br_m < SMAX) br_m++;
      end
      if (tk ^ pt) begin
        if (mp_m < SMAX) mp_m++;
      end
    end
    if (clr) begin
      br_m = 0;
      mp_m = 0;
    end
    check_outputs("step");
  endtask

  task automatic idle(input logic [31:0] ifpc);
    step(0, 0, 0, 8, 0, 0, 0, 0, 0, ifpc);
  endtask

  task automatic br(input int code, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] pc, input bit pt);
    step(1, 0, 0, code, a, b, pc, pt, 0, pc);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] a, b, pc;
    n_checks = 0;
    n_errors = 0;
    model_reset();
    rst_n = 1'b0;
    bus.if_pc = 32'h40; bus.ex_valid = 0; bus.ex_stall = 0; bus.ex_flush = 0;
    bus.ex_branch = 4'd8; bus.ex_op_a = 0; bus.ex_op_b = 0; bus.ex_pc = 0;
    bus.ex_pred_taken = 0; bus.stat_clr = 0;

    // 1: reset state
    #12;
    check("rst_pred", bus.pred_taken, 0);
    check_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2: BEQ equal at 0x40, predicted not taken
    br(0, 5, 5, 32'h40, 0);
    check("t2_taken", bus.res_taken, 1);
    check("t2_mispredict", bus.res_mispredict, 1);
    idle(32'h40);
    check("t2_pred_after", bus.pred_taken, 1);

    // 3: train 0x80 up to saturation, one not-taken, alias at 0x180
    for (int i = 0; i < 5; i++) br(3, 1, 0, 32'h80, 1);
    br(5, 1, 0, 32'h80, 1);
    check("t3_blz_taken", bus.res_taken, 0);
    idle(32'h180);
    check("t3_alias_pred", bus.pred_taken, 1);

    // 4: signed boundaries and a non-branch code
    br(5, 32'h8000_0000, 0, 32'h100, 0);
    check("t4_bltz_min", bus.res_taken, 1);
    br(2, 0, 0, 32'h104, 0);
    check("t4_bgez_zero", bus.res_taken, 1);
    br(3, 0, 0, 32'h108, 0);
    check("t4_bgtz_zero", bus.res_taken, 0);
    br(4, 32'hFFFF_FFFF, 0, 32'h10C, 0);
    check("t4_blez_m1", bus.res_taken, 1);
    br(9, 5, 5, 32'h40, 1);
    check("t4_code9_taken", bus.res_taken, 0);
    check("t4_code9_mp", bus.res_mispredict, 1);
    idle(32'h40);

    // 5: stall, flush-over-stall, link
    for (int i = 0; i < 3; i++) step(1, 1, 0, 3, 7, 0, 32'h200, 0, 0, 32'h200);
    step(1, 0, 0, 3, 7, 0, 32'h200, 0, 0, 32'h200);
    idle(32'h200);
    check("t5_no_repeat", bus.res_valid, 0);
    step(1, 1, 1, 0, 3, 3, 32'h204, 0, 0, 32'h204);
    idle(32'h204);
    br(6, 32'hFFFF_FFFF, 0, 32'h208, 1);
    check("t5_link", bus.res_link, 1);
    check("t5_link_taken", bus.res_taken, 0);

    // 6: statistic saturation and clear
    step(0, 0, 0, 8, 0, 0, 0, 0, 1, 32'h0);
    for (int i = 0; i < 20; i++) br(1, 1, 2, 32'h300, 0);
    check("t6_br_sat", bus.br_count, 15);
    check("t6_mp_sat", bus.mp_count, 15);
    step(1, 0, 0, 1, 1, 2, 32'h300, 0, 1, 32'h300);
    check("t6_clr_br", bus.br_count, 0);
    check("t6_clr_mp", bus.mp_count, 0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      a  = rand_op();
      b  = ($urandom_range(0, 1) == 1) ? a : rand_op();
      pc = $urandom & 32'hFFFF_FFFC;
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), int'($urandom_range(0, 11)), a, b, pc,
           1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0),
           ($urandom_range(0, 1) == 1) ? pc : ($urandom & 32'hFFFF_FFFC));
    end

    // Reset asserted mid-stream with an instruction in flight
    for (int i = 0; i < 4; i++) br(1, 1, 2, 32'h40, 0);
    bus.ex_valid = 1; bus.ex_stall = 0; bus.ex_flush = 0; bus.ex_branch = 4'd0;
    bus.ex_op_a = 9; bus.ex_op_b = 9; bus.ex_pc = 32'h40; bus.ex_pred_taken = 0;
    bus.stat_clr = 0; bus.if_pc = 32'h40;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst");
    check("midrst_pred", bus.pred_taken, 0);
    @(posedge clk); #1;
    check_outputs("midrst_hold");
    for (int i = 0; i < 8; i++) begin
      bus.if_pc = 32'h40 + 32'(i * 4);
      #1;
      check("midrst_init", bus.pred_taken, bht_m[idx_of(bus.if_pc)] >= 2);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    br(0, 9, 9, 32'h40, 0);
    br(0, 9, 9, 32'h40, 0);
    idle(32'h40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
